bids_cmd_sequencer: RTL and testbench

Upstream command stage for the bid auction FSM. Buffers host-issued controller commands (opcode + data) in a FIFO and replays them onto the auction controller inputs (C_op, C_data, C_start) only while the auction reports ready. Expands a ROUND pseudo-command into a timed C_start window and captures per-command error responses into sticky status for the host.

---
 rtl/bids_seq_pkg.sv | 32 +++
 rtl/bids_cmd_fifo.sv | 47 ++++
 rtl/bids_cmd_sequencer.sv | 178 +++++++++++++++++
 tb/tb_bids_cmd_sequencer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bids_seq_pkg.sv
// Shared types for the bid-auction command sequencer: opcodes, FSM states, FIFO entry layout.
package bids_seq_pkg;

    typedef enum logic [3:0] {
        NO_OP        = 4'd0,
        UNLOCK       = 4'd1,
        LOCK         = 4'd2,
        LOADX        = 4'd3,
        LOADY        = 4'd4,
        LOADZ        = 4'd5,
        SETMASK      = 4'd6,
        SETTIMER     = 4'd7,
        SETBIDCHARGE = 4'd8,
        ROUND        = 4'd15
    } opcode_t;

    localparam logic [3:0] NOERROR = 4'd0;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_START     = 2'd2,
        S_WAIT_OVER = 2'd3
    } seq_state_t;

    // Default-width view of one queued command; the top packs {op, data} the same way.
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] data;
    } cmd_entry_t;

endpackage

// File: rtl/bids_cmd_fifo.sv
// Synchronous command FIFO with single-cycle flush; pointers carry one extra wrap bit.
module bids_cmd_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Flush wins over both ports so nothing written in the flush cycle survives.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/bids_cmd_sequencer.sv
// Replays queued host commands onto the auction controller, expands ROUND into a timed
// C_start window with a round-over watchdog, and keeps sticky error status for the host.
module bids_cmd_sequencer
    import bids_seq_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 flush,
    output logic [3:0]           ctl_op,
    output logic [DATAWIDTH-1:0] ctl_data,
    output logic                 ctl_start,
    input  logic                 ctl_ready,
    input  logic [3:0]           ctl_err,
    input  logic                 ctl_round_over,
    output logic                 busy,
    output logic                 err_valid,
    output logic [3:0]           err_code,
    output logic [3:0]           err_op,
    output logic [7:0]           err_count,
    output logic                 timeout_err,
    input  logic                 err_clr,
    output seq_state_t           dbg_state
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    // Host handshake: a command is accepted on a cycle where in_valid && in_ready;
    // in_ready depends only on FIFO fullness (and reset), never on a same-cycle pop.
    seq_state_t           state_q;
    logic [3:0]           op_q;
    logic [DATAWIDTH-1:0] data_q;
    logic                 start_q;
    logic [DATAWIDTH-1:0] cnt_q;
    logic [WDW-1:0]       wdog_q;
    logic                 err_valid_q;
    logic [3:0]           err_code_q;
    logic [3:0]           err_op_q;
    logic [7:0]           err_count_q;
    logic [7:0]           err_count_d;
    logic                 timeout_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [3:0]           head_op;
    logic [DATAWIDTH-1:0] head_data;
    logic                 err_hit;
    logic [3:0]           err_src_op;
    logic                 timeout_hit;

    bids_cmd_fifo #(
        .WIDTH (4 + DATAWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .push_i  (in_valid && in_ready),
        .wdata_i ({in_op, in_data}),
        .pop_i   (fifo_pop),
        .rdata_o ({head_op, head_data}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready = !fifo_full && !reset;
    assign fifo_pop = (state_q == S_IDLE) && !fifo_empty && ctl_ready && !flush;
    assign busy     = !fifo_empty || (state_q != S_IDLE);

    // Errors are attributed to the command on the bus; during a round that is ROUND itself.
    assign err_hit    = ((state_q == S_ISSUE) || (state_q == S_START)) && (ctl_err != NOERROR);
    assign err_src_op = (state_q == S_START) ? ROUND : op_q;
    assign timeout_hit = (state_q == S_WAIT_OVER) && !flush && !ctl_round_over &&
                         (wdog_q <= WDW'(1));

    always_comb begin
        err_count_d = err_count_q;
        if (err_hit) begin
            if (err_clr)                  err_count_d = 8'd1;
            else if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end else if (err_clr) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= NO_OP;
            data_q  <= '0;
            start_q <= 1'b0;
            cnt_q   <= '0;
            wdog_q  <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            op_q    <= NO_OP;
            data_q  <= '0;
            start_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fifo_pop) begin
                        if (head_op == ROUND) begin
                            start_q <= 1'b1;
                            op_q    <= NO_OP;
                            data_q  <= '0;
                            cnt_q   <= (head_data == '0) ? DATAWIDTH'(1) : head_data;
                            state_q <= S_START;
                        end else begin
                            op_q    <= head_op;
                            data_q  <= head_data;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    op_q    <= NO_OP;
                    data_q  <= '0;
                    state_q <= S_IDLE;
                end
                S_START: begin
                    if (cnt_q <= DATAWIDTH'(1)) begin
                        start_q <= 1'b0;
                        wdog_q  <= WDW'(TIMEOUT);
                        state_q <= S_WAIT_OVER;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_WAIT_OVER: begin
                    if (ctl_round_over || wdog_q <= WDW'(1)) state_q <= S_IDLE;
                    else                                     wdog_q  <= wdog_q - 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            err_op_q    <= '0;
            err_count_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            err_valid_q <= err_hit;
            err_count_q <= err_count_d;
            if (err_hit) begin
                err_code_q <= ctl_err;
                err_op_q   <= err_src_op;
            end else if (err_clr) begin
                err_code_q <= '0;
                err_op_q   <= '0;
            end
            if (timeout_hit)  timeout_q <= 1'b1;
            else if (err_clr) timeout_q <= 1'b0;
        end
    end

    assign ctl_op      = op_q;
    assign ctl_data    = data_q;
    assign ctl_start   = start_q;
    assign err_valid   = err_valid_q;
    assign err_code    = err_code_q;
    assign err_op      = err_op_q;
    assign err_count   = err_count_q;
    assign timeout_err = timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_bids_cmd_sequencer.sv
// Directed bench for bids_cmd_sequencer: issue timing, rounds, FIFO limits, errors, watchdog, flush.
module tb_bids_cmd_sequencer;
    import bids_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_data;
    logic        flush;
    logic [3:0]  ctl_op;
    logic [31:0] ctl_data;
    logic        ctl_start;
    logic        ctl_ready;
    logic [3:0]  ctl_err;
    logic        ctl_round_over;
    logic        busy;
    logic        err_valid;
    logic [3:0]  err_code;
    logic [3:0]  err_op;
    logic [7:0]  err_count;
    logic        timeout_err;
    logic        err_clr;
    seq_state_t  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q[$];

    bids_cmd_sequencer #(.DATAWIDTH(32), .DEPTH(8), .TIMEOUT(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_data        (in_data),
        .flush          (flush),
        .ctl_op         (ctl_op),
        .ctl_data       (ctl_data),
        .ctl_start      (ctl_start),
        .ctl_ready      (ctl_ready),
        .ctl_err        (ctl_err),
        .ctl_round_over (ctl_round_over),
        .busy           (busy),
        .err_valid      (err_valid),
        .err_code       (err_code),
        .err_op         (err_op),
        .err_count      (err_count),
        .timeout_err    (timeout_err),
        .err_clr        (err_clr),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic push(input logic [3:0] op, input logic [31:0] d);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_op(input logic [3:0] op, input int budget, input string name);
        int n = 0;
        while (ctl_op !== op && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ctl_op !== op) begin
            errors++;
            $display("FAIL %s: ctl_op=%0d, wanted %0d within %0d cycles", name, ctl_op, op, budget);
        end
    endtask

    task automatic wait_start(input int budget, input string name);
        int n = 0;
        while (ctl_start !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ctl_start !== 1'b1) begin
            errors++;
            $display("FAIL %s: ctl_start never rose within %0d cycles", name, budget);
        end
    endtask

    // Measures how many cycles ctl_start stays high; flags any non-NO_OP opcode meanwhile.
    task automatic start_width(input int budget, output int width, output logic op_clean);
        width    = 0;
        op_clean = 1'b1;
        while (ctl_start === 1'b1 && width < budget) begin
            if (ctl_op !== 4'd0) op_clean = 1'b0;
            width++;
            @(negedge clk);
        end
    endtask

    task automatic collect(input int budget, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            if (ctl_op !== 4'd0) begin
                logic [35:0] e;
                e = exp_q.pop_front();
                checks++;
                if ({ctl_op, ctl_data} !== e) begin
                    errors++;
                    $display("FAIL %s: got op=%0d data=%h, wanted op=%0d data=%h",
                             name, ctl_op, ctl_data, e[35:32], e[31:0]);
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d commands never issued", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_data = '0; flush = 1'b0;
        ctl_ready = 1'b0; ctl_err = '0; ctl_round_over = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: in_ready=%b, wanted 0", in_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({ctl_op, ctl_data, ctl_start, busy} !== 38'd0) begin
            errors++;
            $display("FAIL reset_ctl: op=%0d data=%h start=%b busy=%b, wanted all 0",
                     ctl_op, ctl_data, ctl_start, busy);
        end
        checks++;
        if ({err_valid, err_code, err_op, err_count, timeout_err, in_ready} !== 19'd1) begin
            errors++;
            $display("FAIL reset_status: ev=%b code=%0d op=%0d cnt=%0d to=%b rdy=%b, wanted 0s and rdy=1",
                     err_valid, err_code, err_op, err_count, timeout_err, in_ready);
        end
    endtask

    task automatic test_issue;
        ctl_ready = 1'b1;
        push(LOADX, 32'h64);
        push(LOCK, 32'hAB);
        wait_op(LOADX, 5, "issue_loadx");
        checks++;
        if (ctl_data !== 32'h64) begin
            errors++; $display("FAIL issue_loadx_data: data=%h, wanted 64", ctl_data);
        end
        @(negedge clk);
        checks++;
        if ({ctl_op, ctl_data} !== 36'd0) begin
            errors++; $display("FAIL issue_gap: op=%0d data=%h, wanted NO_OP/0", ctl_op, ctl_data);
        end
        @(negedge clk);
        checks++;
        if ({ctl_op, ctl_data} !== {4'd2, 32'hAB}) begin
            errors++; $display("FAIL issue_lock: op=%0d data=%h, wanted 2/ab", ctl_op, ctl_data);
        end
        @(negedge clk);
        checks++;
        if ({ctl_op, busy, err_count} !== 13'd0) begin
            errors++;
            $display("FAIL issue_done: op=%0d busy=%b err_count=%0d, wanted 0/0/0", ctl_op, busy, err_count);
        end
    endtask

    task automatic test_round;
        int   w;
        logic clean;
        ctl_ready = 1'b1;
        push(ROUND, 32'd5);
        wait_start(5, "round5_rise");
        start_width(40, w, clean);
        checks++;
        if (w != 5 || !clean) begin
            errors++; $display("FAIL round5_width: width=%0d op_clean=%b, wanted 5/1", w, clean);
        end
        repeat (2) @(negedge clk);
        ctl_round_over = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL round5_busy_wait: busy=%b, wanted 1", busy);
        end
        @(negedge clk);
        ctl_round_over = 1'b0;
        checks++;
        if ({busy, timeout_err} !== 2'b00) begin
            errors++; $display("FAIL round5_over: busy=%b timeout=%b, wanted 0/0", busy, timeout_err);
        end
        push(ROUND, 32'd0);
        wait_start(5, "round0_rise");
        start_width(40, w, clean);
        checks++;
        if (w != 1) begin
            errors++; $display("FAIL round0_width: width=%0d, wanted 1", w);
        end
        ctl_round_over = 1'b1;
        @(negedge clk);
        ctl_round_over = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL round0_over: busy=%b, wanted 0", busy);
        end
    endtask

    task automatic test_ready_gate;
        logic quiet = 1'b1;
        ctl_ready = 1'b0;
        exp_q.push_back({4'd4, 32'h11});  push(LOADY, 32'h11);
        exp_q.push_back({4'd12, 32'h22}); push(4'd12, 32'h22);
        exp_q.push_back({4'd6, 32'h33});  push(SETMASK, 32'h33);
        repeat (4) begin
            if (ctl_op !== 4'd0) quiet = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!quiet || busy !== 1'b1) begin
            errors++; $display("FAIL ready_gate_hold: quiet=%b busy=%b, wanted 1/1", quiet, busy);
        end
        ctl_ready = 1'b1;
        collect(20, "ready_gate_order");
    endtask

    task automatic test_full;
        int extra = 0;
        ctl_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({4'(1 + i), 32'h100 + 32'(i)});
            push(4'(1 + i), 32'h100 + 32'(i));
        end
        checks++;
        if ({in_ready, busy} !== 2'b01) begin
            errors++; $display("FAIL full_flag: in_ready=%b busy=%b, wanted 0/1", in_ready, busy);
        end
        push(LOADZ, 32'hDEAD);
        ctl_ready = 1'b1;
        @(negedge clk);
        ctl_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL full_pop_ready: in_ready=%b, wanted 1", in_ready);
        end
        ctl_ready = 1'b1;
        collect(40, "full_order");
        repeat (6) begin
            if (ctl_op !== 4'd0) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL full_ninth_dropped: extra=%0d busy=%b, wanted 0/0", extra, busy);
        end
    endtask

    task automatic test_errors;
        ctl_ready = 1'b1;
        push(UNLOCK, 32'd0);
        wait_op(UNLOCK, 5, "err1_issue");
        ctl_err = 4'd2;
        @(negedge clk);
        ctl_err = 4'd0;
        checks++;
        if ({err_valid, err_code, err_op, err_count} !== {1'b1, 4'd2, 4'd1, 8'd1}) begin
            errors++;
            $display("FAIL err1_capture: ev=%b code=%0d op=%0d cnt=%0d, wanted 1/2/1/1",
                     err_valid, err_code, err_op, err_count);
        end
        @(negedge clk);
        checks++;
        if ({err_valid, err_count} !== {1'b0, 8'd1}) begin
            errors++; $display("FAIL err1_pulse: ev=%b cnt=%0d, wanted 0/1", err_valid, err_count);
        end
        push(LOCK, 32'd7);
        wait_op(LOCK, 5, "err2_issue");
        ctl_err = 4'd3;
        @(negedge clk);
        ctl_err = 4'd0;
        checks++;
        if ({err_code, err_op, err_count} !== {4'd3, 4'd2, 8'd2}) begin
            errors++;
            $display("FAIL err2_capture: code=%0d op=%0d cnt=%0d, wanted 3/2/2", err_code, err_op, err_count);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if ({err_code, err_op, err_count} !== 16'd0) begin
            errors++;
            $display("FAIL err_clr: code=%0d op=%0d cnt=%0d, wanted 0/0/0", err_code, err_op, err_count);
        end
        push(UNLOCK, 32'd0);
        wait_op(UNLOCK, 5, "err3_issue");
        ctl_err = 4'd5;
        err_clr = 1'b1;
        @(negedge clk);
        ctl_err = 4'd0;
        err_clr = 1'b0;
        checks++;
        if ({err_code, err_op, err_count} !== {4'd5, 4'd1, 8'd1}) begin
            errors++;
            $display("FAIL err_clr_vs_new: code=%0d op=%0d cnt=%0d, wanted 5/1/1", err_code, err_op, err_count);
        end
    endtask

    task automatic test_reset_mid_round;
        ctl_ready = 1'b1;
        push(ROUND, 32'd50);
        wait_start(5, "midreset_rise");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ctl_start, in_ready, busy, err_count, err_code} !== 15'd0) begin
            errors++;
            $display("FAIL midreset: start=%b rdy=%b busy=%b cnt=%0d code=%0d, wanted all 0",
                     ctl_start, in_ready, busy, err_count, err_code);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_saturate_timeout;
        int   w;
        int   m = 0;
        logic clean;
        ctl_ready = 1'b1;
        push(ROUND, 32'd300);
        wait_start(5, "sat_rise");
        ctl_err = 4'd9;
        start_width(400, w, clean);
        ctl_err = 4'd0;
        checks++;
        if (w != 300 || {err_count, err_op, err_code} !== {8'd255, 4'd15, 4'd9}) begin
            errors++;
            $display("FAIL saturate: width=%0d cnt=%0d op=%0d code=%0d, wanted 300/255/15/9",
                     w, err_count, err_op, err_code);
        end
        while (timeout_err !== 1'b1 && m < 40) begin
            @(negedge clk);
            m++;
        end
        checks++;
        if (m != 16 || timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout: cycles=%0d flag=%b busy=%b, wanted 16/1/0", m, timeout_err, busy);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if ({timeout_err, err_count} !== 9'd0) begin
            errors++; $display("FAIL timeout_clr: flag=%b cnt=%0d, wanted 0/0", timeout_err, err_count);
        end
    endtask

    task automatic test_flush;
        int act = 0;
        ctl_ready = 1'b1;
        push(ROUND, 32'd10);
        push(LOADX, 32'd7);
        push(LOADY, 32'd8);
        wait_start(5, "flush_rise");
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = LOADX;
        in_data  = 32'h99;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({ctl_start, ctl_op, busy, in_ready} !== 7'b0000001) begin
            errors++;
            $display("FAIL flush_abort: start=%b op=%0d busy=%b rdy=%b, wanted 0/0/0/1",
                     ctl_start, ctl_op, busy, in_ready);
        end
        repeat (6) begin
            if (ctl_op !== 4'd0 || ctl_start !== 1'b0) act++;
            @(negedge clk);
        end
        checks++;
        if (act != 0) begin
            errors++; $display("FAIL flush_empty: %0d active cycles after flush, wanted 0", act);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_issue();
        test_round();
        test_ready_gate();
        test_full();
        test_errors();
        test_reset_mid_round();
        test_saturate_timeout();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
